// File: rtl/gray_step_sequencer.sv
// gray_step_sequencer: command-driven N-bit step counter with gray-coded output.
// A requester can CLEAR, LOAD or RUN the counter up/down by M steps. A completion
// pulse (done) and a wrap pulse (wrap) are registered; abort ends a RUN early.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_op/cmd_arg are sampled only on that edge. cmd_ready is high only in IDLE,
// so a requester holding cmd_valid during a RUN simply waits; nothing is queued
// or dropped.
module gray_step_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_arg,
  input  logic         abort,
  output logic [N-1:0] gray_count,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output logic [0:0]   state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] OP_RUN_UP   = 2'b00;
  localparam logic [1:0] OP_RUN_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD     = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state;
  logic [N-1:0] bin;
  logic [N-1:0] remaining;
  logic         dir;

  // Status outputs derived purely from the FSM state and the step register.
  always_comb begin
    cmd_ready  = (state == IDLE);
    busy       = (state == RUN);
    state_dbg  = state;
    gray_count = bin ^ (bin >> 1);
  end

  // Command acceptance, stepping, and the registered done/wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= ZERO;
      remaining <= ZERO;
      dir       <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      // Pulses default low; each branch raises them only on its own edge.
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_CLEAR: begin
                bin  <= ZERO;
                done <= 1'b1;
              end
              OP_LOAD: begin
                bin  <= cmd_arg;
                done <= 1'b1;
              end
              OP_RUN_UP, OP_RUN_DOWN: begin
                // A zero-length run completes immediately without stepping.
                if (cmd_arg == ZERO) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd_arg;
                  dir       <= cmd_op[0];
                  state     <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // Abort wins over a final step landing on the same edge.
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            if (!dir) begin
              bin  <= bin + ONE;
              wrap <= &bin;
            end else begin
              bin  <= bin - ONE;
              wrap <= ~|bin;
            end
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Directed bench for gray_step_sequencer (N = 4): a vector table for the
// single-edge behaviour plus hand-written sequences for held commands and
// asynchronous reset in the middle of a run.
module tb_gray_step_sequencer;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_arg;
  logic         abort;
  logic [N-1:0] gray_count;
  logic         busy;
  logic         done;
  logic         wrap;
  logic [0:0]   state_dbg;

  always #5 clk = ~clk;

  gray_step_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .abort      (abort),
    .gray_count (gray_count),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Observed word: {gray[3:0], busy, done, wrap, cmd_ready}
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_out(input logic [3:0] g, input logic b, input logic d,
                            input logic w, input logic r);
    exp_q.push_back({g, b, d, w, r});
  endtask

  task automatic check(input string name);
    logic [7:0] exp;
    logic [7:0] act;
    act = {gray_count, busy, done, wrap, cmd_ready};
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: no expected value queued, actual=%b", name, act);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: actual {gray,busy,done,wrap,ready}=%b required=%b",
                 name, act, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [3:0] arg, input logic ab);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    abort     = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [3:0] arg;
    logic       ab;
    logic [3:0] gray;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       ready;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    // Test 1: RUN_UP 5 from 0.
    vecs[0]  = '{1'b1, 2'b00, 4'd5,  1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1};
    // Test 2: LOAD 14, RUN_UP 3 wrapping through 15 -> 0 -> 1.
    vecs[6]  = '{1'b1, 2'b10, 4'd14, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 4'd3,  1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1};
    // Test 3: CLEAR, RUN_DOWN 2 wrapping 0 -> 15 -> 14.
    vecs[11] = '{1'b1, 2'b11, 4'd7,  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 2'b01, 4'd2,  1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1};
    // Test 4: CLEAR, RUN_UP 10 aborted on the 4th RUN edge -> 3 steps.
    vecs[15] = '{1'b1, 2'b11, 4'd0,  1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 2'b00, 4'd10, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 2'b00, 4'd0,  1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 2'b00, 4'd0,  1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1};
    // Abort in IDLE is ignored: no done, nothing moves.
    vecs[21] = '{1'b0, 2'b00, 4'd0,  1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1};
    // RUN_UP 1 with abort on its only RUN edge: abort wins, no step.
    vecs[22] = '{1'b1, 2'b00, 4'd1,  1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 2'b00, 4'd0,  1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 1'b0);
    tick();
    tick();
    expect_out(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].arg, vecs[i].ab);
      tick();
      expect_out(vecs[i].gray, vecs[i].busy, vecs[i].done, vecs[i].wrap, vecs[i].ready);
      check($sformatf("vec%0d", i));
    end

    // Held LOAD while busy: bin is 3 here. RUN_UP 3 -> 4,5,6.
    drive(1'b1, 2'b00, 4'd3, 1'b0);
    tick();
    expect_out(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_run_accept");
    drive(1'b1, 2'b10, 4'd9, 1'b0);
    tick();
    expect_out(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_step1_not_loaded");
    tick();
    expect_out(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_step2_not_loaded");
    tick();
    expect_out(4'b0101, 1'b0, 1'b1, 1'b0, 1'b1);
    check("held_run_done");
    tick();
    expect_out(4'b1101, 1'b0, 1'b1, 1'b0, 1'b1);
    check("held_load_accepted");

    // Asynchronous reset mid-run: bin 9 -> 10 -> 11 then reset.
    drive(1'b1, 2'b00, 4'd5, 1'b0);
    tick();
    drive(1'b0, 2'b00, 4'd0, 1'b0);
    tick();
    tick();
    expect_out(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_run");
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("async_reset_immediate");
    tick();
    expect_out(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_no_done");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    drive(1'b1, 2'b00, 4'd0, 1'b0);
    tick();
    expect_out(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    check("run_zero_done");
    drive(1'b0, 2'b00, 4'd0, 1'b0);
    tick();
    expect_out(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("run_zero_done_one_cycle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
